// File: rtl/branch_resolve_bht_pkg.sv
// rtl/branch_resolve_bht_pkg.sv - shared branch funct3 codes, BHT counter states and illegal-code helper
// Purpose: common constants for the branch resolver and its comparator.
// Ports: none (package).
package branch_resolve_bht_pkg;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // One bit per funct3 value; set bits are the two unused encodings 010 and 011.
  localparam logic [7:0] BR_ILLEGAL_MASK = 8'b0000_1100;

  typedef enum logic [1:0] {
    BHT_STRONG_NT = 2'b00,
    BHT_WEAK_NT   = 2'b01,
    BHT_WEAK_T    = 2'b10,
    BHT_STRONG_T  = 2'b11
  } bht_state_e;

  function automatic logic br_illegal(input logic [2:0] f3);
    return BR_ILLEGAL_MASK[f3];
  endfunction

  // Saturating 2-bit counter step toward the actual outcome.
  function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken && cur != BHT_STRONG_T)
      nxt = cur + 2'd1;
    else if (!taken && cur != BHT_STRONG_NT)
      nxt = cur - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - combinational conditional-branch comparator
// Purpose: evaluates a branch condition selected by funct3.
// Ports:
//   rs1, rs2  in  XLEN  operands
//   f3        in  3     funct3 condition select
//   taken     out 1     condition true (always 0 for illegal codes)
//   illegal   out 1     funct3 is 010 or 011
module branch_cond
  import branch_resolve_bht_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      f3,
  output logic            taken,
  output logic            illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = br_illegal(f3);
    case (f3)
      BR_EQ:   taken = (rs1 == rs2);
      BR_NE:   taken = (rs1 != rs2);
      BR_LT:   taken = ($signed(rs1) <  $signed(rs2));
      BR_GE:   taken = ($signed(rs1) >= $signed(rs2));
      BR_LTU:  taken = (rs1 <  rs2);
      BR_GEU:  taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_bht.sv
// rtl/branch_resolve_bht.sv - branch resolver with 2-bit BHT training and statistics
// Purpose: resolves conditional branches one cycle after issue, produces the
// redirect target and mispredict flag, trains the BHT read by fetch, and counts
// resolved branches and mispredictions.
// Ports:
//   clk, rst           in   clock, synchronous active-high reset
//   pred_pc            in   XLEN  fetch lookup PC
//   pred_taken         out  1     MSB of the BHT counter at index(pred_pc)
//   res_valid          in   1     resolution request
//   res_is_branch      in   1     request is a conditional branch
//   res_pc, res_imm    in   XLEN  branch PC and sign-extended immediate
//   res_rs1, res_rs2   in   XLEN  operands
//   res_f3             in   3     funct3
//   res_pred_taken     in   1     prediction used by fetch
//   flush              in   1     kill the same-cycle request
//   out_valid/out_taken/out_mispredict/out_target/out_illegal  out  registered result
//   branch_cnt, mispredict_cnt  out  CNT_W  saturating statistics
module branch_resolve_bht
  import branch_resolve_bht_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_LSB     = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic             res_is_branch,
  input  logic [XLEN-1:0]  res_pc,
  input  logic [XLEN-1:0]  res_imm,
  input  logic [XLEN-1:0]  res_rs1,
  input  logic [XLEN-1:0]  res_rs2,
  input  logic [2:0]       res_f3,
  input  logic             res_pred_taken,
  input  logic             flush,
  output logic             out_valid,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic [XLEN-1:0]  out_target,
  output logic             out_illegal,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]      bht [BHT_ENTRIES];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic            cond_taken;
  logic            cond_illegal;
  logic            acc;
  logic            upd;
  logic            mispredict;
  logic [XLEN-1:0] target;
  logic [1:0]      cnt_next;
  logic            unused_pc_bits;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .rs1     (res_rs1),
    .rs2     (res_rs2),
    .f3      (res_f3),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  assign pred_idx = pred_pc[IDX_LSB +: IDX_W];
  assign res_idx  = res_pc[IDX_LSB +: IDX_W];

  // Reads the array as it stands before this cycle's update: no write bypass.
  assign pred_taken = bht[pred_idx][1];

  // Only the index bits of the lookup PC matter; fold the rest away.
  assign unused_pc_bits = ^pred_pc;

  assign acc        = res_valid & res_is_branch & ~flush & ~rst;
  assign upd        = acc & ~cond_illegal;
  assign mispredict = (cond_taken != res_pred_taken) & ~cond_illegal;
  assign target     = cond_taken ? (res_pc + res_imm) : (res_pc + XLEN'(4));
  assign cnt_next   = bht_next(bht[res_idx], cond_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_mispredict <= 1'b0;
      out_target     <= '0;
      out_illegal    <= 1'b0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht[i] <= BHT_WEAK_NT;
    end else begin
      out_valid      <= acc;
      out_mispredict <= acc & mispredict;
      if (acc) begin
        out_taken   <= cond_taken;
        out_target  <= target;
        out_illegal <= cond_illegal;
      end
      if (upd) begin
        bht[res_idx] <= cnt_next;
        if (branch_cnt != '1)
          branch_cnt <= branch_cnt + CNT_W'(1);
        if (mispredict && mispredict_cnt != '1)
          mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb/tb_branch_resolve_bht.sv - scoreboard bench for branch_resolve_bht
module tb_branch_resolve_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        res_valid, res_is_branch, res_pred_taken, flush;
  logic [31:0] res_pc, res_imm, res_rs1, res_rs2;
  logic [2:0]  res_f3;
  logic        out_valid, out_taken, out_mispredict, out_illegal;
  logic [31:0] out_target, branch_cnt, mispredict_cnt;

  branch_resolve_bht dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_is_branch(res_is_branch), .res_pc(res_pc),
    .res_imm(res_imm), .res_rs1(res_rs1), .res_rs2(res_rs2), .res_f3(res_f3),
    .res_pred_taken(res_pred_taken), .flush(flush), .out_valid(out_valid),
    .out_taken(out_taken), .out_mispredict(out_mispredict), .out_target(out_target),
    .out_illegal(out_illegal), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        taken;
    logic        misp;
    logic        illegal;
    logic [31:0] target;
  } res_t;

  res_t        sb[$];
  res_t        hold;
  int          m_bht[64];
  int unsigned m_bcnt, m_mcnt;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd63);
  endfunction

  function automatic void model_reset();
    foreach (m_bht[i]) m_bht[i] = 1;
    m_bcnt = 0;
    m_mcnt = 0;
    hold = '{taken: 1'b0, misp: 1'b0, illegal: 1'b0, target: 32'h0};
  endfunction

  // Reference branch semantics straight from the funct3 table.
  function automatic void ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                   output logic tk, output logic il);
    il = 1'b0;
    case (f3)
      3'd0: tk = (a == b);
      3'd1: tk = (a != b);
      3'd4: tk = ($signed(a) < $signed(b));
      3'd5: tk = ($signed(a) >= $signed(b));
      3'd6: tk = (a < b);
      3'd7: tk = (a >= b);
      default: begin tk = 1'b0; il = 1'b1; end
    endcase
  endfunction

  // Called at a negedge; drives one cycle of stimulus and returns at the next negedge.
  task automatic step(input bit r, input bit v, input bit b, input bit fl, input bit pt,
                      input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] a, input logic [31:0] bb, input logic [31:0] ppc);
    logic tk, il, acc;
    res_t e;
    rst = r; res_valid = v; res_is_branch = b; flush = fl; res_pred_taken = pt;
    res_f3 = f3; res_pc = pc; res_imm = imm; res_rs1 = a; res_rs2 = bb; pred_pc = ppc;
    #1;
    chk("pred_taken", pred_taken, (m_bht[idx(ppc)] >= 2) ? 32'd1 : 32'd0);
    ref_cond(f3, a, bb, tk, il);
    acc = v & b & ~fl & ~r;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (acc) begin
      e.taken   = tk;
      e.illegal = il;
      e.misp    = (tk != pt) && !il;
      e.target  = tk ? pc + imm : pc + 32'd4;
      sb.push_back(e);
      hold = e;
      if (!il) begin
        if (tk) m_bht[idx(pc)] = (m_bht[idx(pc)] == 3) ? 3 : m_bht[idx(pc)] + 1;
        else    m_bht[idx(pc)] = (m_bht[idx(pc)] == 0) ? 0 : m_bht[idx(pc)] - 1;
        m_bcnt++;
        if (e.misp) m_mcnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] ppc);
    step(0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, ppc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_valid", 32'(out_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("out_taken", 32'(out_taken), 32'(e.taken));
            chk("out_mispredict", 32'(out_mispredict), 32'(e.misp));
            chk("out_illegal", 32'(out_illegal), 32'(e.illegal));
            chk("out_target", out_target, e.target);
          end
        end else begin
          chk("idle_mispredict", 32'(out_mispredict), 32'd0);
          chk("hold_taken", 32'(out_taken), 32'(hold.taken));
          chk("hold_illegal", 32'(out_illegal), 32'(hold.illegal));
          chk("hold_target", out_target, hold.target);
        end
        chk("branch_cnt", branch_cnt, m_bcnt);
        chk("mispredict_cnt", mispredict_cnt, m_mcnt);
      end
    end
  end

  initial begin
    logic [31:0] vals[5];
    logic [31:0] pc, ppc, a, bb, imm;
    rst = 1; res_valid = 0; res_is_branch = 0; flush = 0; res_pred_taken = 0;
    res_f3 = 0; res_pc = 0; res_imm = 0; res_rs1 = 0; res_rs2 = 0; pred_pc = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset_pred_taken", 32'(pred_taken), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_branch_cnt", branch_cnt, 32'd0);
    chk("reset_out_target", out_target, 32'd0);
    model_reset();
    @(negedge clk);
    mon_en = 1;

    // BEQ taken, predicted not-taken
    step(0, 1, 1, 0, 0, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 32'h100);
    chk("beq_taken", 32'(out_taken), 32'd1);
    chk("beq_mispredict", 32'(out_mispredict), 32'd1);
    chk("beq_target", out_target, 32'h120);
    chk("beq_misp_cnt", mispredict_cnt, 32'd1);

    // Training at 0x40: first lookup sees the pre-update value
    repeat (3) step(0, 1, 1, 0, 0, 3'd4, 32'h40, 32'h8, 32'hFFFF_FFFF, 32'd1, 32'h40);
    idle(32'h40);
    chk("trained_pred", 32'(pred_taken), 32'd1);
    repeat (2) step(0, 1, 1, 0, 1, 3'd0, 32'h40, 32'h8, 32'd1, 32'd2, 32'h40);
    idle(32'h40);

    // Signed vs unsigned
    step(0, 1, 1, 0, 0, 3'd6, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'h0);
    chk("bltu_target", out_target, 32'h204);
    step(0, 1, 1, 0, 0, 3'd5, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'h0);
    chk("bge_taken", 32'(out_taken), 32'd0);
    step(0, 1, 1, 0, 0, 3'd7, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'h0);
    chk("bgeu_taken", 32'(out_taken), 32'd1);

    // Target wrap and illegal funct3
    step(0, 1, 1, 0, 1, 3'd0, 32'hFFFF_FFF0, 32'h20, 32'd7, 32'd7, 32'h0);
    chk("wrap_target", out_target, 32'h10);
    step(0, 1, 1, 0, 1, 3'd2, 32'h300, 32'h20, 32'd7, 32'd7, 32'h300);
    chk("illegal_flag", 32'(out_illegal), 32'd1);
    step(0, 1, 1, 0, 0, 3'd3, 32'h300, 32'h20, 32'd7, 32'd8, 32'h300);

    // Flush, non-branch, then reset colliding with a live request
    step(0, 1, 1, 1, 0, 3'd0, 32'h40, 32'h20, 32'd1, 32'd1, 32'h40);
    chk("flush_valid", 32'(out_valid), 32'd0);
    step(0, 1, 0, 0, 0, 3'd0, 32'h40, 32'h20, 32'd1, 32'd1, 32'h40);
    repeat (3) step(0, 1, 1, 0, 1, 3'd1, 32'h80, 32'h20, 32'd1, 32'd2, 32'h80);
    step(1, 1, 1, 0, 1, 3'd1, 32'h80, 32'h20, 32'd1, 32'd2, 32'h80);
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    chk("rst_misp_cnt", mispredict_cnt, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    step(0, 1, 1, 0, 0, 3'd0, 32'h80, 32'h20, 32'd1, 32'd2, 32'h80);
    idle(32'h80);
    chk("rst_bht_weak_nt", 32'(pred_taken), 32'd0);

    // Randomised traffic on a small PC window so entries collide
    for (int n = 0; n < 400; n++) begin
      vals[0] = 32'h0; vals[1] = 32'h1; vals[2] = 32'hFFFF_FFFF;
      vals[3] = 32'h8000_0000; vals[4] = $urandom;
      pc  = 32'h1000 + ($urandom_range(0, 15) << 2);
      ppc = ($urandom_range(0, 1) == 1) ? pc : 32'h1000 + ($urandom_range(0, 15) << 2);
      a   = vals[$urandom_range(0, 4)];
      bb  = vals[$urandom_range(0, 4)];
      imm = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 255)) << 1);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 9,
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
           pc, imm, a, bb, ppc);
    end

    idle(32'h0);
    idle(32'h0);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
- Parametrised successor to the combinational branch comparator.
- Resolves conditional branches one cycle after issue, computes the redirect PC, and flags mispredictions.
- Trains a direct-mapped table of 2-bit saturating counters (BHT) that the fetch stage reads for taken/not-taken predictions.
- Keeps saturating branch and mispredict statistics counters.
- Sits between the execute stage (resolution inputs) and fetch (prediction lookup, redirect).

Parameters:
- XLEN, 32, operand/PC width.
- BHT_ENTRIES, 64, number of counters; power of two, 2..1024.
- IDX_LSB, 2, lowest PC bit used for the BHT index; index = pc[IDX_LSB +: log2(BHT_ENTRIES)].
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- pred_pc  in  XLEN  fetch PC for lookup.
- pred_taken  out  1  combinational: MSB of the counter at index(pred_pc).
- res_valid  in  1  resolution request this cycle.
- res_is_branch  in  1  instruction is a conditional branch (can_branch).
- res_pc  in  XLEN  PC of the branch.
- res_imm  in  XLEN  sign-extended B-immediate.
- res_rs1, res_rs2  in  XLEN  operands.
- res_f3  in  3  funct3.
- res_pred_taken  in  1  prediction fetch used for this branch.
- flush  in  1  kill the request presented this cycle.
- out_valid  out  1  registered result valid.
- out_taken  out  1  registered actual outcome.
- out_mispredict  out  1  registered; out_taken != prediction.
- out_target  out  XLEN  registered redirect PC.
- out_illegal  out  1  registered; f3 is 010 or 011.
- branch_cnt  out  CNT_W  resolved-branch count.
- mispredict_cnt  out  CNT_W  misprediction count.

Behaviour:
- Reset, synchronous:
  - All out_* = 0 and both statistics counters = 0.
  - Every BHT entry = 2'b01 (weakly not-taken).
  - Reset wins over all other inputs in the same cycle.
  - A request presented in the reset cycle is dropped.
- Accept condition: acc = res_valid & res_is_branch & ~flush & ~rst. Latency is 1 cycle; there is no backpressure and a new request may be accepted every cycle.
- Condition decode on f3:
  - 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010 and 011 are illegal: taken = 0 and illegal = 1.
- At the edge after acc:
  - out_valid = 1.
  - out_taken = taken.
  - out_mispredict = (taken != res_pred_taken) & ~illegal.
  - out_target = taken ? res_pc + res_imm : res_pc + 4, truncated to XLEN (wraps modulo 2^XLEN).
  - out_illegal = illegal.
- If not acc: out_valid = 0, out_mispredict = 0; the other out_* hold their previous values.
- res_valid with res_is_branch = 0 produces out_valid = 0 and makes no BHT or counter change.
- BHT update, same edge as the result, only when acc & ~illegal:
  - Taken: increment the counter, saturating at 11.
  - Not taken: decrement the counter, saturating at 00.
- Read during write: when pred_pc and res_pc map to the same index in the same cycle, pred_taken returns the pre-update value. There is no bypass.
- Statistics:
  - branch_cnt increments on acc & ~illegal.
  - mispredict_cnt increments when additionally mispredict.
  - Both saturate at all-ones.
- Flush mid-operation: flush kills only the same-cycle request. A result already registered still appears; the pipeline owner squashes it downstream.

Decomposition:
- Shared defines file: the BR_* funct3 constants (already present) and a new BR_ILLEGAL mask helper.
- Natural sub-module: branch_cond, a combinational, XLEN-parametrised comparator returning taken and illegal.
- BHT array and counters stay in the top module.

Test Plan:
- Reset, then pred_pc=0x100 -> pred_taken=0; then out_valid=0, branch_cnt=0.
- BEQ: rs1=rs2=5, pc=0x100, imm=0x20, pred=0 -> next cycle out_taken=1, mispredict=1, target=0x120, mispredict_cnt=1.
- Training: pc=0x40 BLT with rs1=-1, rs2=1, taken, issued 3 times back-to-back -> counter 01→10→11→11; pred_taken(0x40)=1 after the first update; read in the same cycle as the first update returns 0.
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=1 -> BLTU not taken, target=pc+4; BGE not taken; BGEU taken.
- Wrap and illegal: pc=0xFFFFFFF0, imm=0x20, taken -> target=0x10. f3=010 -> out_illegal=1, taken=0, no BHT or counter change.
- Flush and reset collisions: res_valid with flush=1 -> out_valid=0, no update. Reset asserted mid-stream -> all BHT entries 01 and counters 0 on the next cycle.
